debug_response_tx: RTL and testbench
====================================

DEBUG_RESPONSE_TX -- requirements
Module: debug_response_tx

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: clock cycles the block waits after updating code before it samples result and size; legal range 1..15.
REQ-002 Port clock  in  1  single clock; all state changes on its rising edge.
REQ-003 Port reset  in  1  one clock; reset is asynchronous and active-high.
REQ-004 Port rx_data  in  8  command byte from the UART receiver.
REQ-005 Port rx_done  in  1  one-cycle pulse; rx_data is valid in that cycle.
REQ-006 Port code  out  8  registered command byte driven to the debug decoder.
REQ-007 Port result  in  32  decoder response value.
REQ-008 Port size  in  2  decoder response length code; the response is size+1 bytes.
REQ-009 Port tx_data  out  8  byte presented to the UART transmitter.
REQ-010 Port tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
REQ-011 Port tx_done  in  1  one-cycle pulse from the UART transmitter when a byte has finished.
REQ-012 Port busy  out  1  high from command acceptance until the last tx_done.
REQ-013 Port overrun  out  1  one-cycle pulse when a command byte is dropped.

Function
REQ-014 The state machine SHALL have the states IDLE, SETTLE, CAPTURE, SEND and WAIT.
REQ-015 In IDLE, an rx_done pulse SHALL load code <= rx_data, clear the settle counter, set busy and move to SETTLE on the same edge.
REQ-016 SETTLE SHALL hold for exactly SETTLE_CYCLES cycles and then move to CAPTURE.
REQ-017 CAPTURE SHALL register result into a 32-bit shift register and size+1 into a 3-bit byte counter, then move to SEND.
REQ-018 Bytes SHALL be sent most significant first, starting from the lowest size+1 bytes of result: size=2'b11 sends [31:24],[23:16],[15:8],[7:0]; size=2'b00 sends only [7:0].
REQ-019 SEND SHALL drive tx_data with the current byte and assert tx_start for exactly one cycle, decrement the byte counter and move to WAIT.
REQ-020 tx_data SHALL remain stable from tx_start until the matching tx_done.
REQ-021 In WAIT, on tx_done: if bytes remain, the block SHALL shift to the next byte and move to SEND (next tx_start one cycle after tx_done); otherwise it SHALL drop busy and move to IDLE.
REQ-022 Latency: the first tx_start SHALL occur SETTLE_CYCLES+2 rising edges after the edge that samples rx_done.
REQ-023 code SHALL hold the last accepted command indefinitely, including in IDLE, because codes 0x38 and 0x3F define the stepping clock level.
REQ-024 An rx_done pulse in any state other than IDLE SHALL be dropped: code is unchanged and overrun pulses in the same cycle.
REQ-025 If rx_done and the final tx_done coincide, the command SHALL be dropped with overrun asserted; acceptance is possible only from IDLE.
REQ-026 tx_done in IDLE, SETTLE or CAPTURE SHALL be ignored.
REQ-027 result and size SHALL be sampled only in CAPTURE; changes to them at any other time SHALL have no effect.

Reset
REQ-028 Asserting reset SHALL immediately force state IDLE, code=8'h00, tx_data=8'h00, tx_start=0, busy=0, overrun=0, and clear the shift register and counters.
REQ-029 Reset mid-transfer SHALL abort the response; no further tx_start is issued after reset is released until a new rx_done.

Verification
REQ-030 rx_data=0x40 with rx_done, result=0x12345678, size=2'b11, tx_done returned 5 cycles after each tx_start -> code=0x40; four tx_start pulses with tx_data 0x12, 0x34, 0x56, 0x78; busy falls on the 4th tx_done.
REQ-031 rx_data=0x1C with rx_done, result=0x0000001F, size=2'b00 -> one tx_start with tx_data=0x1F; tx_start occurs 4 edges after rx_done (SETTLE_CYCLES=2).
REQ-032 rx_data=0x3F is accepted, then rx_data=0x38 arrives during WAIT -> overrun pulses and code stays 0x3F; a later 0x38 sent in IDLE sets code=0x38 and returns 0x55.
REQ-033 result changes from 0xAAAAAAAA to 0x0 during WAIT after capture -> all transmitted bytes are 0xAA.
REQ-034 reset asserted after the 2nd byte of a 4-byte response -> outputs are at reset values immediately; with no new rx_done there is no tx_start for 20 cycles.
REQ-035 tx_done pulse while in IDLE -> no state change and no tx_start.

Source files
------------

// File: rtl/debug_response_tx.sv
// -----------------------------------------------------------------------------
// debug_response_tx
//
// Accepts one command byte from a UART receiver and presents it to a debug
// decoder on `code`. After a settle delay it captures the decoder's response
// (`result`, `size`) and streams size+1 bytes to a UART transmitter, most
// significant byte first. One command is handled at a time. A command byte
// that arrives while a response is still in progress is dropped and flagged
// on `overrun`.
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   rx_data   in   [7:0]  command byte, valid while rx_done is high
//   rx_done   in   one-cycle receive strobe
//   code      out  [7:0]  last accepted command, held until the next one
//   result    in   [31:0] decoder response value
//   size      in   [1:0]  response length code, size+1 bytes
//   tx_data   out  [7:0]  byte offered to the transmitter
//   tx_start  out  one-cycle transmit request
//   tx_done   in   one-cycle byte-complete strobe from the transmitter
//   busy      out  high from command acceptance until the last tx_done
//   overrun   out  one-cycle pulse when a command byte is dropped
//
// SETTLE_CYCLES is the decoder settle time, legal range 1..15.
// -----------------------------------------------------------------------------
module debug_response_tx #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_done,
   output logic [7:0]  code,
   input  logic [31:0] result,
   input  logic [1:0]  size,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_done,
   output logic        busy,
   output logic        overrun
);

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      CAPTURE,
      SEND,
      WAIT
   } state_t;

   // Settle counter terminal value: SETTLE is left on the cycle the counter
   // reaches this value, giving exactly SETTLE_CYCLES cycles in SETTLE.
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t      state_q,  state_d;
   logic [7:0]  code_q,   code_d;
   logic [3:0]  settle_q, settle_d;
   logic [31:0] shift_q,  shift_d;   // byte on air always sits in [31:24]
   logic [2:0]  bytes_q,  bytes_d;   // bytes not yet requested

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         code_q   <= 8'h00;
         settle_q <= 4'd0;
         shift_q  <= 32'h0000_0000;
         bytes_q  <= 3'd0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         settle_q <= settle_d;
         shift_q  <= shift_d;
         bytes_q  <= bytes_d;
      end
   end

   // NOTE: every signal assigned here gets its hold value first, so no path
   // through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      settle_d = settle_q;
      shift_d  = shift_q;
      bytes_d  = bytes_q;

      unique case (state_q)
         IDLE: begin
            if (rx_done) begin
               code_d   = rx_data;
               settle_d = 4'd0;
               state_d  = SETTLE;
            end
         end

         SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               state_d = CAPTURE;
            end else begin
               settle_d = settle_q + 4'd1;
            end
         end

         CAPTURE: begin
            // Left-align the lowest size+1 bytes so the first byte to send
            // lands in [31:24]; ~size equals 3-size for a 2-bit code.
            shift_d = result << {~size, 3'b000};
            bytes_d = {1'b0, size} + 3'd1;
            state_d = SEND;
         end

         SEND: begin
            bytes_d = bytes_q - 3'd1;
            state_d = WAIT;
         end

         WAIT: begin
            if (tx_done) begin
               if (bytes_q != 3'd0) begin
                  shift_d = shift_q << 8;
                  state_d = SEND;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign code     = code_q;
   // tx_data only moves on the tx_done edge, so it is stable for the whole
   // transmission of the byte it accompanies.
   assign tx_data  = shift_q[31:24];
   assign tx_start = (state_q == SEND);
   assign busy     = (state_q != IDLE);
   // Acceptance happens only from IDLE, so any strobe seen elsewhere is lost,
   // including one coinciding with the final tx_done.
   assign overrun  = rx_done && (state_q != IDLE);

endmodule

// File: tb/tb_debug_response_tx.sv
// -----------------------------------------------------------------------------
// tb_debug_response_tx
//
// Self-checking bench for debug_response_tx. The bench plays both the UART
// transmitter (answers every tx_start with a tx_done a programmable number of
// cycles later) and the decoder (drives result/size per command). Expected
// byte streams come from a table of directed vectors and, for random traffic,
// from a byte-selection model of the response rule.
// -----------------------------------------------------------------------------
module tb_debug_response_tx;

   localparam int SETTLE = 2;

   logic        clock;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_done;
   logic [7:0]  code;
   logic [31:0] result;
   logic [1:0]  size;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_done;
   logic        busy;
   logic        overrun;

   logic        tx_done_auto;
   logic        tx_done_man;
   assign tx_done = tx_done_auto | tx_done_man;

   debug_response_tx #(.SETTLE_CYCLES(SETTLE)) dut (
      .clock    (clock),
      .reset    (reset),
      .rx_data  (rx_data),
      .rx_done  (rx_done),
      .code     (code),
      .result   (result),
      .size     (size),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_done  (tx_done),
      .busy     (busy),
      .overrun  (overrun)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Transmitter model and tx_start monitor (all activity on negedge)
   // ---------------------------------------------------------------------
   logic [7:0] got_q[$];
   int         start_q[$];
   bit         auto_done  = 1'b1;
   int         done_delay = 5;
   int         done_cnt   = 0;
   int         dones      = 0;
   logic       prev_start = 1'b0;
   logic [7:0] last_data  = 8'h00;

   always @(negedge clock) begin
      tx_done_auto = 1'b0;
      if (reset) begin
         done_cnt   = 0;
         prev_start = 1'b0;
      end else begin
         if (tx_start) begin
            check("tx_start_width", {31'd0, prev_start}, 32'd0);
            got_q.push_back(tx_data);
            start_q.push_back(cyc);
            last_data = tx_data;
            if (auto_done) done_cnt = done_delay;
         end else if (done_cnt > 0) begin
            check("tx_data_stable", {24'd0, tx_data}, {24'd0, last_data});
            done_cnt--;
            if (done_cnt == 0) begin
               tx_done_auto = 1'b1;
               dones++;
            end
         end
         prev_start = tx_start;
      end
   end

   // ---------------------------------------------------------------------
   // Reference: bytes size..0 of result, first byte left-aligned
   // ---------------------------------------------------------------------
   function automatic logic [31:0] model_seq(input logic [31:0] r, input logic [1:0] s);
      logic [31:0] q;
      q = '0;
      for (int i = 0; i <= int'(s); i++) q[31 - 8*i -: 8] = r[8*(int'(s) - i) +: 8];
      return q;
   endfunction

   // ---------------------------------------------------------------------
   // One command: send, optionally disturb the decoder / inject a second
   // command while busy, then compare the observed stream with expectations
   // ---------------------------------------------------------------------
   int acc;

   task automatic run_txn(input logic [7:0] d, input logic [31:0] r, input logic [1:0] s,
                          input int dly, input bit perturb, input logic [31:0] pert_val,
                          input bit inject, input logic [7:0] inj,
                          input logic [7:0] ecode, input int en, input logic [31:0] eseq,
                          input string tag);
      int n;
      bit injected;
      done_delay = dly;
      auto_done  = 1'b1;
      got_q.delete();
      start_q.delete();
      @(negedge clock);
      result  = r;
      size    = s;
      rx_data = d;
      rx_done = 1'b1;
      acc     = cyc;
      @(negedge clock);
      rx_done  = 1'b0;
      n        = 0;
      injected = 1'b0;
      while (busy !== 1'b0 && n < 400) begin
         @(negedge clock);
         n++;
         rx_done = 1'b0;
         if (perturb && got_q.size() > 0) begin
            result = pert_val;
            size   = ~s;
         end
         if (inject && !injected && got_q.size() > 0 && busy === 1'b1) begin
            rx_data  = inj;
            rx_done  = 1'b1;
            injected = 1'b1;
            #1;
            check({tag, "_overrun"}, {31'd0, overrun}, 32'd1);
         end
      end
      rx_done = 1'b0;
      check({tag, "_timeout"}, {31'd0, busy}, 32'd0);
      @(negedge clock);
      check({tag, "_code"}, {24'd0, code}, {24'd0, ecode});
      check({tag, "_nbytes"}, got_q.size(), en);
      for (int k = 0; k < en && k < got_q.size(); k++)
         check($sformatf("%s_byte%0d", tag, k), {24'd0, got_q[k]}, {24'd0, eseq[31 - 8*k -: 8]});
      if (start_q.size() > 0)
         check({tag, "_latency"}, start_q[0] - acc, SETTLE + 2);
      for (int k = 1; k < start_q.size(); k++)
         check($sformatf("%s_gap%0d", tag, k), start_q[k] - start_q[k-1], dly + 1);
   endtask

   // ---------------------------------------------------------------------
   // Directed vector table
   // ---------------------------------------------------------------------
   typedef struct packed {
      logic [7:0]  rx;
      logic [31:0] res;
      logic [1:0]  sz;
      logic [3:0]  dly;
      logic [7:0]  exp_code;
      logic [2:0]  exp_n;
      logic [31:0] exp_seq;
   } vec_t;

   vec_t vecs [6];

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: got=running expected=finished");
      $fatal(1, "bench time limit expired");
   end

   initial begin : main
      int n;
      logic [7:0]  d;
      logic [31:0] r;
      logic [1:0]  s;

      vecs[0] = '{8'h40, 32'h1234_5678, 2'b11, 4'd5, 8'h40, 3'd4, 32'h1234_5678};
      vecs[1] = '{8'h1C, 32'h0000_001F, 2'b00, 4'd5, 8'h1C, 3'd1, 32'h1F00_0000};
      vecs[2] = '{8'h38, 32'h0000_0055, 2'b00, 4'd1, 8'h38, 3'd1, 32'h5500_0000};
      vecs[3] = '{8'hA5, 32'hDEAD_BEEF, 2'b01, 4'd2, 8'hA5, 3'd2, 32'hBEEF_0000};
      vecs[4] = '{8'h3F, 32'hCAFE_F00D, 2'b10, 4'd3, 8'h3F, 3'd3, 32'hFEF0_0D00};
      vecs[5] = '{8'h00, 32'h89AB_CDEF, 2'b11, 4'd1, 8'h00, 3'd4, 32'h89AB_CDEF};

      reset       = 1'b1;
      rx_data     = 8'h00;
      rx_done     = 1'b0;
      result      = 32'h0;
      size        = 2'b00;
      tx_done_man = 1'b0;

      // Reset values
      repeat (3) @(negedge clock);
      check("rst_code",     {24'd0, code},    32'd0);
      check("rst_tx_data",  {24'd0, tx_data}, 32'd0);
      check("rst_tx_start", {31'd0, tx_start}, 32'd0);
      check("rst_busy",     {31'd0, busy},    32'd0);
      check("rst_overrun",  {31'd0, overrun}, 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // Table-driven directed responses
      for (int i = 0; i < 6; i++)
         run_txn(vecs[i].rx, vecs[i].res, vecs[i].sz, int'(vecs[i].dly), 1'b0, 32'h0,
                 1'b0, 8'h00, vecs[i].exp_code, int'(vecs[i].exp_n), vecs[i].exp_seq,
                 $sformatf("vec%0d", i));

      // Command dropped during WAIT, then accepted from IDLE
      run_txn(8'h3F, 32'h0000_A1B2, 2'b01, 4, 1'b0, 32'h0, 1'b1, 8'h38,
              8'h3F, 2, 32'hA1B2_0000, "drop38");
      run_txn(8'h38, 32'h0000_0055, 2'b00, 3, 1'b0, 32'h0, 1'b0, 8'h00,
              8'h38, 1, 32'h5500_0000, "accept38");

      // Decoder output changes after capture must not leak into the stream
      run_txn(8'h5A, 32'hAAAA_AAAA, 2'b11, 2, 1'b1, 32'h0000_0000, 1'b0, 8'h00,
              8'h5A, 4, 32'hAAAA_AAAA, "late_result");

      // Command coinciding with the final tx_done is dropped
      auto_done = 1'b0;
      got_q.delete();
      @(negedge clock);
      result = 32'h0000_00C3; size = 2'b00; rx_data = 8'h11; rx_done = 1'b1;
      @(negedge clock);
      rx_done = 1'b0;
      n = 0;
      while (got_q.size() == 0 && n < 50) begin @(negedge clock); n++; end
      check("coinc_start_seen", got_q.size(), 1);
      repeat (2) @(negedge clock);
      rx_data = 8'h22; rx_done = 1'b1; tx_done_man = 1'b1;
      #1;
      check("coinc_overrun", {31'd0, overrun}, 32'd1);
      @(negedge clock);
      rx_done = 1'b0; tx_done_man = 1'b0;
      check("coinc_busy", {31'd0, busy}, 32'd0);
      check("coinc_code", {24'd0, code}, 32'h11);
      repeat (10) @(negedge clock);
      check("coinc_no_start", got_q.size(), 1);
      check("coinc_idle", {31'd0, busy}, 32'd0);

      // tx_done while idle is ignored
      got_q.delete();
      tx_done_man = 1'b1;
      @(negedge clock);
      tx_done_man = 1'b0;
      repeat (5) @(negedge clock);
      check("idle_done_start", got_q.size(), 0);
      check("idle_done_busy", {31'd0, busy}, 32'd0);
      check("idle_done_code", {24'd0, code}, 32'h11);
      auto_done = 1'b1;

      // Reset in the middle of a four-byte response
      done_delay = 5;
      dones = 0;
      got_q.delete();
      @(negedge clock);
      result = 32'h1234_5678; size = 2'b11; rx_data = 8'h40; rx_done = 1'b1;
      @(negedge clock);
      rx_done = 1'b0;
      n = 0;
      while (dones < 2 && n < 200) begin @(negedge clock); n++; end
      check("mid_rst_two_done", dones, 2);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("mid_rst_code",     {24'd0, code},    32'd0);
      check("mid_rst_tx_data",  {24'd0, tx_data}, 32'd0);
      check("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
      check("mid_rst_busy",     {31'd0, busy},    32'd0);
      check("mid_rst_overrun",  {31'd0, overrun}, 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      got_q.delete();
      repeat (20) @(negedge clock);
      check("mid_rst_silent", got_q.size(), 0);
      check("mid_rst_idle", {31'd0, busy}, 32'd0);

      // Random traffic against the byte-selection model
      for (int t = 0; t < 20; t++) begin
         d = 8'($urandom);
         r = $urandom;
         s = 2'($urandom);
         run_txn(d, r, s, int'($urandom_range(1, 6)), 1'b1, $urandom,
                 1'($urandom_range(0, 1)), 8'($urandom),
                 d, int'(s) + 1, model_seq(r, s), $sformatf("rand%0d", t));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
